// File: rtl/calculator_1.sv
// Keypad adder: two one-hot digit keys -> A+B on LEDs, 7-segment and HD44780 LCD line 1.
// Key press to led/seg in 3 clk; no backpressure, LCD refreshes are queued behind a dirty flag.
module calculator_1 #(
  parameter int LCD_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw,
  output logic [3:0]  led,
  output logic [7:0]  seg,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, DONE} state_t;

  localparam int DW = (LCD_DIV > 1) ? $clog2(LCD_DIV) : 1;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hFC;
      4'd1:    seg_code = 8'h60;
      4'd2:    seg_code = 8'hDA;
      4'd3:    seg_code = 8'hF2;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'hB6;
      4'd6:    seg_code = 8'hBE;
      4'd7:    seg_code = 8'hE0;
      4'd8:    seg_code = 8'hFE;
      4'd9:    seg_code = 8'hF6;
      default: seg_code = 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] ones_of(input logic [4:0] s);
    ones_of = (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    asc = {4'h3, d};
  endfunction

  // ---------------- input conditioning ----------------
  logic [11:0] sw_s1_q, sw_s2_q;
  logic        key_prev_q;
  logic        key_vld;
  logic [3:0]  key_dig;
  logic        key_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_prev_q <= 1'b0;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      key_prev_q <= key_vld;
    end
  end

  always_comb begin
    key_dig = 4'd0;
    key_vld = (sw_s2_q[1:0] == 2'b00);
    case (sw_s2_q[11:2])
      10'b1000000000: key_dig = 4'd0;
      10'b0100000000: key_dig = 4'd1;
      10'b0010000000: key_dig = 4'd2;
      10'b0001000000: key_dig = 4'd3;
      10'b0000100000: key_dig = 4'd4;
      10'b0000010000: key_dig = 4'd5;
      10'b0000001000: key_dig = 4'd6;
      10'b0000000100: key_dig = 4'd7;
      10'b0000000010: key_dig = 4'd8;
      10'b0000000001: key_dig = 4'd9;
      default:        key_vld = 1'b0;
    endcase
  end

  assign key_press = key_vld && !key_prev_q;

  // ---------------- entry FSM ----------------
  state_t      state_q;
  logic [3:0]  a_q, b_q, led_q;
  logic [4:0]  sum_q;
  logic [7:0]  seg_q;
  logic [4:0]  sum_d;
  logic        key_acc;

  assign sum_d   = {1'b0, a_q} + {1'b0, key_dig};
  assign key_acc = key_press && (state_q != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      led_q   <= '0;
      seg_q   <= 8'h00;
    end else begin
      case (state_q)
        WAIT_A: if (key_press) begin
          a_q     <= key_dig;
          led_q   <= key_dig;
          seg_q   <= seg_code(key_dig);
          state_q <= WAIT_B;
        end
        WAIT_B: if (key_press) begin
          b_q     <= key_dig;
          led_q   <= key_dig;
          sum_q   <= sum_d;
          seg_q   <= seg_code(ones_of(sum_d)) | {7'b0, (sum_d >= 5'd10)};
          state_q <= DONE;
        end
        DONE:    ;
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign led = led_q;
  assign seg = seg_q;

  // ---------------- LCD controller ----------------
  // seq 0..3 = init commands, 4 = set DDRAM address, 5..10 = the six characters.
  logic [DW-1:0] div_q;
  logic          tick;
  logic          run_q, dirty_q;
  logic [3:0]    seq_q;
  logic [1:0]    phase_q;
  logic [3:0]    snap_a_q, snap_b_q;
  logic [4:0]    snap_sum_q;
  state_t        snap_st_q;
  logic          e_q, rs_q;
  logic [7:0]    dat_q;
  logic          byte_rs;
  logic [7:0]    byte_dat;

  assign tick = (div_q == DW'(LCD_DIV - 1));

  always_comb begin
    byte_rs  = 1'b1;
    byte_dat = 8'h20;
    case (seq_q)
      4'd0:  begin byte_rs = 1'b0; byte_dat = 8'h38; end
      4'd1:  begin byte_rs = 1'b0; byte_dat = 8'h0C; end
      4'd2:  begin byte_rs = 1'b0; byte_dat = 8'h06; end
      4'd3:  begin byte_rs = 1'b0; byte_dat = 8'h01; end
      4'd4:  begin byte_rs = 1'b0; byte_dat = 8'h80; end
      4'd5:  if (snap_st_q != WAIT_A) byte_dat = asc(snap_a_q);
      4'd6:  byte_dat = 8'h2B;
      4'd7:  if (snap_st_q == DONE) byte_dat = asc(snap_b_q);
      4'd8:  byte_dat = 8'h3D;
      4'd9:  if (snap_sum_q >= 5'd10) byte_dat = 8'h31;
      4'd10: if (snap_st_q == DONE) byte_dat = asc(ones_of(snap_sum_q));
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      run_q      <= 1'b1;
      dirty_q    <= 1'b0;
      seq_q      <= 4'd0;
      phase_q    <= 2'd0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
      snap_sum_q <= '0;
      snap_st_q  <= WAIT_A;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      dat_q      <= 8'h00;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;

      // A key landing on the same cycle a refresh starts keeps dirty set.
      if (key_acc)
        dirty_q <= 1'b1;
      else if (!run_q && dirty_q)
        dirty_q <= 1'b0;

      if (!run_q) begin
        if (dirty_q) begin
          run_q   <= 1'b1;
          seq_q   <= 4'd4;
          phase_q <= 2'd0;
        end
      end else if (tick) begin
        case (phase_q)
          2'd0: begin
            rs_q    <= byte_rs;
            dat_q   <= byte_dat;
            e_q     <= 1'b0;
            phase_q <= 2'd1;
            if (seq_q == 4'd4) begin
              snap_a_q   <= a_q;
              snap_b_q   <= b_q;
              snap_sum_q <= sum_q;
              snap_st_q  <= state_q;
            end
          end
          2'd1: begin
            e_q     <= 1'b1;
            phase_q <= 2'd2;
          end
          2'd2: begin
            e_q     <= 1'b0;
            phase_q <= 2'd0;
            if (seq_q == 4'd10) run_q <= 1'b0;
            else                seq_q <= seq_q + 4'd1;
          end
          default: phase_q <= 2'd0;
        endcase
      end
    end
  end

  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = dat_q;

endmodule

// File: tb/tb_calculator_1.sv
// Scoreboard bench for calculator_1: directed key sequences, expected display and LCD bytes queued.
module tb_calculator_1;
  localparam int LCD_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sw  = '0;
  logic [3:0]  led;
  logic [7:0]  seg;
  logic        lcd_e, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;

  calculator_1 #(.LCD_DIV(LCD_DIV)) dut (
    .clk(clk), .rst(rst), .sw(sw), .led(led), .seg(seg),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [8:0]  exp_lcd[$];
  logic [11:0] exp_disp[$];
  logic [11:0] last_disp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push_disp(input logic [3:0] l, input logic [7:0] s);
    if ({l, s} != last_disp) exp_disp.push_back({l, s});
    last_disp = {l, s};
  endtask

  task automatic push_refresh(input logic [7:0] p0, input logic [7:0] p2,
                              input logic [7:0] p4, input logic [7:0] p5);
    exp_lcd.push_back(9'h080);
    exp_lcd.push_back({1'b1, p0});
    exp_lcd.push_back(9'h12B);
    exp_lcd.push_back({1'b1, p2});
    exp_lcd.push_back(9'h13D);
    exp_lcd.push_back({1'b1, p4});
    exp_lcd.push_back({1'b1, p5});
  endtask

  task automatic push_init();
    exp_lcd.push_back(9'h038);
    exp_lcd.push_back(9'h00C);
    exp_lcd.push_back(9'h006);
    exp_lcd.push_back(9'h001);
    push_refresh(8'h20, 8'h20, 8'h20, 8'h20);
  endtask

  task automatic press_raw(input logic [11:0] p, input int hold, input int gap);
    sw = p;
    repeat (hold) @(negedge clk);
    sw = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic press(input int bit_idx, input int hold, input int gap);
    logic [11:0] p;
    p = '0;
    p[bit_idx] = 1'b1;
    press_raw(p, hold, gap);
  endtask

  task automatic wait_lcd(input int settle);
    int t;
    t = 0;
    while (exp_lcd.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("lcd_drain", exp_lcd.size(), 0);
    repeat (settle) @(negedge clk);
  endtask

  task automatic do_reset();
    push_disp(4'd0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_seg", seg, 8'h00);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_data", lcd_data, 8'h00);
    push_init();
    rst = 1'b1;
  endtask

  // Display monitor: every change of {led,seg} must match the next queued value.
  logic [11:0] prev_disp = '0;
  always @(negedge clk) begin
    if ({led, seg} !== prev_disp) begin
      prev_disp = {led, seg};
      if (exp_disp.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL disp_unexpected: got led=%0h seg=%0h, want no change", led, seg);
      end else begin
        check("disp", {led, seg}, exp_disp.pop_front());
      end
    end
  end

  // LCD monitor: bytes taken at each lcd_e strobe, plus strobe width and hold timing.
  logic       prev_e = 1'b0;
  int         hi_cnt = 0;
  int         since_chg = 100;
  int         since_fall = 100;
  logic [8:0] prev_bus = '0;
  logic [8:0] cap_bus = '0;
  always @(negedge clk) begin
    check("lcd_rw", lcd_rw, 0);
    if (!rst) begin
      prev_e     = 1'b0;
      hi_cnt     = 0;
      since_chg  = 100;
      since_fall = 100;
      prev_bus   = {lcd_rs, lcd_data};
    end else begin
      if (prev_e && !lcd_e) since_fall = 0;
      else if (since_fall < 1000) since_fall++;
      if ({lcd_rs, lcd_data} !== prev_bus) begin
        check("lcd_stable_strobe", {lcd_e, prev_e}, 0);
        check("lcd_hold_after", since_fall >= LCD_DIV, 1);
        since_chg = 0;
        prev_bus  = {lcd_rs, lcd_data};
      end else if (since_chg < 1000) begin
        since_chg++;
      end
      if (lcd_e && !prev_e) begin
        check("lcd_setup", since_chg >= LCD_DIV, 1);
        cap_bus = {lcd_rs, lcd_data};
        hi_cnt  = 1;
      end else if (lcd_e) begin
        hi_cnt++;
      end
      if (!lcd_e && prev_e) begin
        check("lcd_e_width", hi_cnt, LCD_DIV);
        if (exp_lcd.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL lcd_unexpected: got rs/data %0h, want none", cap_bus);
        end else begin
          check("lcd_byte", cap_bus, exp_lcd.pop_front());
        end
      end
      prev_e = lcd_e;
    end
  end

  initial begin
    int t;
    #1 rst = 1'b0;

    // 4 + 5 = 9, refreshed separately
    do_reset();
    wait_lcd(20);
    push_disp(4'd4, 8'h66);
    push_refresh(8'h34, 8'h20, 8'h20, 8'h20);
    press(7, 4, 8);
    wait_lcd(20);
    push_disp(4'd5, 8'hF6);
    push_refresh(8'h34, 8'h35, 8'h20, 8'h39);
    press(6, 4, 8);
    wait_lcd(20);

    // keys in DONE, two keys at once, reserved bit: all ignored
    press(10, 4, 8);
    press_raw(12'h0C0, 4, 8);
    press_raw(12'h001, 4, 8);
    repeat (150) @(negedge clk);
    check("done_led", led, 4'd5);
    check("done_seg", seg, 8'hF6);

    // 7 + 8 = 15; B lands mid-refresh so a second refresh follows
    do_reset();
    wait_lcd(20);
    push_disp(4'd7, 8'hE0);
    push_refresh(8'h37, 8'h20, 8'h20, 8'h20);
    push_disp(4'd8, 8'hB7);
    push_refresh(8'h37, 8'h38, 8'h31, 8'h35);
    press(4, 5, 5);
    press(3, 5, 5);
    wait_lcd(20);

    // 6 held 20 cycles, then 5 -> 11
    do_reset();
    wait_lcd(20);
    push_disp(4'd6, 8'hBE);
    push_refresh(8'h36, 8'h20, 8'h20, 8'h20);
    press(5, 20, 8);
    wait_lcd(20);
    push_disp(4'd5, 8'h61);
    push_refresh(8'h36, 8'h35, 8'h31, 8'h31);
    press(6, 4, 8);
    wait_lcd(20);

    // 9 + 3 = 12
    do_reset();
    wait_lcd(20);
    push_disp(4'd9, 8'hF6);
    push_refresh(8'h39, 8'h20, 8'h20, 8'h20);
    press(2, 4, 8);
    wait_lcd(20);
    push_disp(4'd3, 8'hDB);
    push_refresh(8'h39, 8'h33, 8'h31, 8'h32);
    press(8, 4, 8);
    wait_lcd(20);

    // reset while lcd_e is high
    do_reset();
    t = 0;
    while (!lcd_e && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("lcd_e_seen", lcd_e, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_lcd_e", lcd_e, 0);
    check("midrst_lcd_rs", lcd_rs, 0);
    check("midrst_lcd_data", lcd_data, 8'h00);
    check("midrst_led", led, 0);
    check("midrst_seg", seg, 8'h00);
    exp_lcd.delete();
    push_init();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_lcd(40);

    check("disp_drain", exp_disp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
